mat_result_uart_tx: RTL
=======================

# mat_result_uart_tx

Downstream stage of the 2x2 matrix multiplier on the FPGA build. Captures the packed 20-bit product matrix when the multiplier raises `valid` and serialises it over a UART 8N1 line, one byte per element. Element order is c00, c01, c10, c11. Lets the board report results to a host without a logic analyser.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Legal values are 2 or more.

Ports:
- `clk`: in, 1. System clock; all logic on the rising edge.
- `rst`: in, 1. Reset, synchronous and active-high.
- `result_in`: in, 20. Packed product matrix: [4:0]=c00, [9:5]=c01, [14:10]=c10, [19:15]=c11, each unsigned 5-bit.
- `valid_in`: in, 1. Result-valid from the multiplier; level or pulse.
- `tx`: out, 1. UART serial output, idle high.
- `busy`: out, 1. High while a frame is in flight.
- `done`: out, 1. One-cycle pulse when the last stop bit completes.
- `overrun`: out, 1. Sticky flag: `valid_in` was seen while busy.

## Operation
- Reset values: `tx`=1, `busy`=0, `done`=0, `overrun`=0. FSM is in IDLE, all counters are 0.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - When `valid_in`=1, latch `result_in` into a 20-bit shadow register.
  - Clear the byte index, then go to START.
  - When `valid_in`=0, stay in IDLE.
- START: drive `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA:
  - Send 8 data bits, LSB first, each for `CLKS_PER_BIT` cycles.
  - Byte k = {3'b000, shadow[5k+4:5k]}, i.e. each element is zero-extended to 8 bits.
  - After bit 7, go to STOP.
- STOP: drive `tx`=1 for `CLKS_PER_BIT` cycles, then:
  - If the byte index is below the last index, increment it and go to START. There is no idle gap between bytes.
  - Otherwise go to IDLE and pulse `done`.
- `busy` is 1 in every state except IDLE.
- Shadow register isolation: `result_in` is sampled only on the capture edge. Later changes to `result_in` do not alter the frame in flight.
- `valid_in`=1 while `busy`=1:
  - The input is ignored and `overrun` is set.
  - `overrun` clears only on `rst`.
  - A `valid_in` held high across a whole frame sets `overrun`, and then starts a new capture in the first IDLE cycle.
- Reset mid-frame:
  - Aborts the frame; all outputs return to their reset values on the next edge.
  - The partial byte is not completed.
  - The next capture restarts at byte 0.
- Counters:
  - The bit-time counter is `$clog2(CLKS_PER_BIT)` bits wide and wraps to 0 at `CLKS_PER_BIT-1`.
  - The bit index is 3 bits; the byte index is 3 bits.

## Timing
- Capture edge T is the edge where the FSM is in IDLE and `valid_in`=1.
- At edge T: `busy` goes to 1 and `tx` goes to 0. Both are registered outputs and are visible in cycle T+1.
- Each frame is 10 bit-times: start, 8 data, stop. A bit-time is exactly `CLKS_PER_BIT` cycles.
- `busy` stays high for exactly N×10×`CLKS_PER_BIT` cycles, where N = number of bytes (4, or 5 with the checksum).
- `done` is high for exactly the first cycle in which `busy`=0.
- A `valid_in` in that same cycle is captured; its start bit follows one cycle later, so `tx` stays high for at least one idle cycle between frames.
- Latency from `valid_in` to the first data bit is 1 + `CLKS_PER_BIT` cycles.

## Configuration
- `MAT_TX_CHECKSUM_EN`:
  - Defined: a 5th byte follows c11, equal to the XOR of the four element bytes. The last byte index is 4, and the frame is 50 bit-times.
  - Undefined: 4 bytes only, the last byte index is 3, the frame is 40 bit-times, and no XOR logic is built.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 unless stated otherwise.
- **Reset:** hold `rst` for 3 cycles → `tx`=1, `busy`=0, `done`=0, `overrun`=0. Hold idle for 20 cycles → `tx` stays 1.
- **All elements 18:** `result_in`=20'h94A52, one-cycle `valid_in` → four bytes 0x12 (data bits 0,1,0,0,1,0,0,0). `busy` is high for 160 cycles, and one `done` pulse follows.
- **Element ordering:** `result_in`=20'h20C41 (c00=1, c01=2, c10=3, c11=4) → bytes 0x01, 0x02, 0x03, 0x04 in that order. Changing `result_in` after capture has no effect on the frame.
- **Overrun:** pulse `valid_in` at cycle 50 of a frame → `overrun`=1 from then on, the frame is unchanged, and no second frame is sent.
- **Reset mid-frame:** assert `rst` during byte 2 → `tx`=1 and `busy`=0 on the next cycle. A fresh `valid_in` with 20'h20C41 then sends 0x01 first.
- **With `MAT_TX_CHECKSUM_EN`:**
  - 20'h20C41 → bytes 0x01, 0x02, 0x03, 0x04, 0x04; `busy` is high for 200 cycles.
  - 20'h94A52 → checksum byte 0x00.

Source files
------------

// File: rtl/mat_result_uart_tx.sv
// mat_result_uart_tx: serialises a captured 2x2 product matrix over UART 8N1.
// Bytes c00,c01,c10,c11 (+ XOR checksum with MAT_TX_CHECKSUM_EN defined).
// Ports: clk, rst (sync, active-high), result_in[19:0], valid_in,
//        tx (idle high), busy, done (1-cycle), overrun (sticky).
module mat_result_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] result_in,
  input  logic        valid_in,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CMAX = CW'(CLKS_PER_BIT - 1);
`ifdef MAT_TX_CHECKSUM_EN
  localparam logic [2:0] LAST = 3'd4;
`else
  localparam logic [2:0] LAST = 3'd3;
`endif

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [2:0]    r_bit, w_bit;
  logic [2:0]    r_byte, w_byte_n;
  logic [19:0]   r_shadow, w_shadow;
  logic          r_tx, w_tx;
  logic          r_busy, w_busy;
  logic          r_done, w_done;
  logic          r_ovr, w_ovr;
  logic [7:0]    w_byte;
  logic [2:0]    w_bit_inc;
  logic          w_last_clk;

  assign w_last_clk = (r_cnt == CMAX);
  assign w_bit_inc  = r_bit + 3'd1;

  always_comb begin
    w_byte = 8'h00;
    case (r_byte)
      3'd0: w_byte = {3'b000, r_shadow[4:0]};
      3'd1: w_byte = {3'b000, r_shadow[9:5]};
      3'd2: w_byte = {3'b000, r_shadow[14:10]};
      3'd3: w_byte = {3'b000, r_shadow[19:15]};
`ifdef MAT_TX_CHECKSUM_EN
      3'd4: w_byte = {3'b000, r_shadow[4:0] ^ r_shadow[9:5]
                      ^ r_shadow[14:10] ^ r_shadow[19:15]};
`endif
      default: w_byte = 8'h00;
    endcase
  end

  always_comb begin
    w_state  = r_state;
    w_cnt    = w_last_clk ? '0 : r_cnt + 1'b1;
    w_bit    = r_bit;
    w_byte_n = r_byte;
    w_shadow = r_shadow;
    w_tx     = r_tx;
    w_busy   = r_busy;
    w_done   = 1'b0;
    // Any valid seen while a frame is in flight is dropped but flagged.
    w_ovr    = r_ovr | (valid_in & r_busy);
    unique case (r_state)
      IDLE: begin
        w_cnt = '0;
        if (valid_in) begin
          w_shadow = result_in;
          w_byte_n = 3'd0;
          w_bit    = 3'd0;
          w_state  = START;
          w_tx     = 1'b0;
          w_busy   = 1'b1;
        end
      end
      START: begin
        if (w_last_clk) begin
          w_state = DATA;
          w_bit   = 3'd0;
          w_tx    = w_byte[0];
        end
      end
      DATA: begin
        if (w_last_clk) begin
          if (r_bit == 3'd7) begin
            w_state = STOP;
            w_tx    = 1'b1;
          end else begin
            w_bit = w_bit_inc;
            w_tx  = w_byte[w_bit_inc];
          end
        end
      end
      STOP: begin
        if (w_last_clk) begin
          if (r_byte < LAST) begin
            w_byte_n = r_byte + 3'd1;
            w_state  = START;
            w_tx     = 1'b0;
          end else begin
            w_state = IDLE;
            w_busy  = 1'b0;
            w_done  = 1'b1;
            w_tx    = 1'b1;
          end
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_bit    <= 3'd0;
      r_byte   <= 3'd0;
      r_shadow <= 20'd0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_bit    <= w_bit;
      r_byte   <= w_byte_n;
      r_shadow <= w_shadow;
      r_tx     <= w_tx;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_ovr    <= w_ovr;
    end
  end

  assign tx      = r_tx;
  assign busy    = r_busy;
  assign done    = r_done;
  assign overrun = r_ovr;

endmodule
